// File: rtl/locked_regbank_dbg_if.sv
// Bus bundle for locked_regbank_dbg.
// master: configuration-bus side (drives requests, samples status).
// slave : the register bank.
//   write/addr/data_in : write request
//   lock/lock_sel      : global / per-register lock set
//   rd_addr            : read address (data_out follows one cycle later)
//   dbg_req/dbg_key    : debug unlock challenge
//   scan_mode          : test mode, zeroizes the bank on entry
//   data_out, lock_status, dbg_unlocked, dbg_lockout, wr_err : status
interface locked_regbank_dbg_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
);
  logic             write;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data_in;
  logic             lock;
  logic [NREGS-1:0] lock_sel;
  logic [AW-1:0]    rd_addr;
  logic             dbg_req;
  logic [WIDTH-1:0] dbg_key;
  logic             scan_mode;
  logic [WIDTH-1:0] data_out;
  logic [NREGS-1:0] lock_status;
  logic             dbg_unlocked;
  logic             dbg_lockout;
  logic             wr_err;

  modport master (
    output write, addr, data_in, lock, lock_sel, rd_addr, dbg_req, dbg_key, scan_mode,
    input  data_out, lock_status, dbg_unlocked, dbg_lockout, wr_err
  );

  modport slave (
    input  write, addr, data_in, lock, lock_sel, rd_addr, dbg_req, dbg_key, scan_mode,
    output data_out, lock_status, dbg_unlocked, dbg_lockout, wr_err
  );
endinterface

// File: rtl/locked_regbank_dbg.sv
// Bank of NREGS lockable WIDTH-bit registers with sticky per-register lock
// bits, a key-checked time-limited debug unlock, a lockout after MAX_FAIL bad
// keys, and zeroize-on-scan-entry.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears all state
//   bus : locked_regbank_dbg_if.slave (requests in, registered status out)
// All outputs come straight from flops (or a decode of the state flops).
module locked_regbank_dbg #(
  parameter int               WIDTH         = 16,
  parameter int               NREGS         = 4,
  parameter int               AW            = $clog2(NREGS),
  parameter logic [WIDTH-1:0] KEY           = WIDTH'(16'hA5C3),
  parameter int               UNLOCK_CYCLES = 256,
  parameter int               MAX_FAIL      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  locked_regbank_dbg_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CHECK, UNLOCKED, LOCKOUT} state_e;

  localparam int             TW         = $clog2(UNLOCK_CYCLES);
  localparam int             FW         = $clog2(MAX_FAIL + 1);
  localparam logic [TW-1:0]  TIMER_INIT = TW'(UNLOCK_CYCLES - 1);
  localparam logic [FW-1:0]  FAIL_LIM   = FW'(MAX_FAIL);
  localparam logic [AW:0]    NREGS_W    = (AW+1)'(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            lock_q, lock_d;
  logic [WIDTH-1:0]            dout_q, dout_d;
  logic [WIDTH-1:0]            key_q;
  logic [TW-1:0]               timer_q;
  logic [FW-1:0]               fail_q;
  logic [FW-1:0]               fail_inc;
  logic                        scan_q;
  logic                        wr_err_q;
  state_e                      state_q;

  logic addr_ok, rd_ok, unlocked, scan_entry, wr_ok;

  // Guards only matter when NREGS is not a power of two.
  assign addr_ok    = {1'b0, bus.addr} < NREGS_W;
  assign rd_ok      = {1'b0, bus.rd_addr} < NREGS_W;
  assign unlocked   = (state_q == UNLOCKED);
  assign scan_entry = bus.scan_mode & ~scan_q;
  // scan_q also blocks the cycle right after scan drops, so a write can
  // never race the zeroize of the scan entry.
  assign wr_ok      = bus.write & addr_ok & (~lock_q[bus.addr] | unlocked) &
                      ~bus.scan_mode & ~scan_q;
  assign fail_inc   = fail_q + 1'b1;

  // Lock request is OR-ed in after the write decision, so a same-cycle
  // write to an unlocked register still lands.
  assign lock_d = lock_q | {NREGS{bus.lock}} | bus.lock_sel;
  assign dout_d = (bus.scan_mode || !rd_ok) ? '0 : regs_q[bus.rd_addr];

  always_comb begin
    regs_d = regs_q;
    if (scan_entry)  regs_d = '0;
    else if (wr_ok)  regs_d[bus.addr] = bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '0;
      lock_q   <= '0;
      dout_q   <= '0;
      scan_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      lock_q   <= lock_d;
      dout_q   <= dout_d;
      scan_q   <= bus.scan_mode;
      wr_err_q <= bus.write & ~wr_ok;
    end
  end

  // Debug unlock FSM. Scan entry aborts a pending check or an open window
  // but never releases LOCKOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      fail_q  <= '0;
      key_q   <= '0;
    end else if (scan_entry && state_q != LOCKOUT) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.dbg_req && !bus.scan_mode) begin
            key_q   <= bus.dbg_key;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (key_q == KEY) begin
            state_q <= UNLOCKED;
            timer_q <= TIMER_INIT;
            fail_q  <= '0;
          end else begin
            fail_q  <= fail_inc;
            state_q <= (fail_inc == FAIL_LIM) ? LOCKOUT : IDLE;
          end
        end
        UNLOCKED: begin
          // timer counts UNLOCK_CYCLES-1 .. 0, giving a window of exactly
          // UNLOCK_CYCLES cycles; Lock relocks immediately.
          if (bus.lock || timer_q == '0) state_q <= IDLE;
          else                           timer_q <= timer_q - 1'b1;
        end
        default: state_q <= LOCKOUT;
      endcase
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.lock_status  = lock_q;
  assign bus.dbg_unlocked = unlocked;
  assign bus.dbg_lockout  = (state_q == LOCKOUT);
  assign bus.wr_err       = wr_err_q;

endmodule

// File: tb/tb_locked_regbank_dbg.sv
module tb_locked_regbank_dbg;
  localparam int          W   = 16;
  localparam int          N   = 4;
  localparam logic [15:0] KEY = 16'hA5C3;
  localparam int          UNL = 256;
  localparam int          MF  = 3;

  logic clk, rst;
  locked_regbank_dbg_if #(.WIDTH(W), .NREGS(N)) bus();

  locked_regbank_dbg #(.WIDTH(W), .NREGS(N), .KEY(KEY), .UNLOCK_CYCLES(UNL), .MAX_FAIL(MF))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] dout;
    logic [3:0]  ls;
    logic        unl;
    logic        lko;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   unl_cnt = 0;

  // Reference model: behaviour stated as "window cycles remaining" and
  // "check pending" rather than a state encoding.
  logic [15:0] m_regs[N];
  bit   [3:0]  m_lk;
  int          m_win;
  bit          m_chk;
  logic [15:0] m_key;
  int          m_fails;
  bit          m_lko;
  bit          m_scan_prev;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_lk = '0; m_win = 0; m_chk = 0; m_key = '0;
    m_fails = 0; m_lko = 0; m_scan_prev = 0;
  endtask

  task automatic model_step();
    exp_t e;
    bit   unl, scan, wr_ok;
    int   a, ra;
    unl   = (m_win > 0);
    scan  = bus.scan_mode;
    a     = int'(bus.addr);
    ra    = int'(bus.rd_addr);
    wr_ok = bus.write && (!m_lk[a] || unl) && !scan && !m_scan_prev;
    e.err  = bus.write && !wr_ok;
    e.dout = scan ? 16'h0 : m_regs[ra];
    if (wr_ok) m_regs[a] = bus.data_in;
    if (scan && !m_scan_prev) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_chk = 0;
      m_win = 0;
    end else if (m_chk) begin
      m_chk = 0;
      if (m_key == KEY) begin
        m_win = UNL;
        m_fails = 0;
      end else begin
        m_fails++;
        if (m_fails == MF) m_lko = 1;
      end
    end else if (unl) begin
      if (bus.lock) m_win = 0;
      else          m_win--;
    end else if (!m_lko && bus.dbg_req && !scan) begin
      m_chk = 1;
      m_key = bus.dbg_key;
    end
    m_lk = m_lk | {4{bus.lock}} | bus.lock_sel;
    m_scan_prev = scan;
    e.ls  = m_lk;
    e.unl = (m_win > 0);
    e.lko = m_lko;
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a registered response every cycle; compare it
  // against the oldest expectation away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("data_out",     bus.data_out,     e.dout);
        chk("lock_status",  bus.lock_status,  e.ls);
        chk("dbg_unlocked", bus.dbg_unlocked, e.unl);
        chk("dbg_lockout",  bus.dbg_lockout,  e.lko);
        chk("wr_err",       bus.wr_err,       e.err);
        if (bus.dbg_unlocked) unl_cnt++;
      end
    end
  end

  task automatic drive(bit wr, int a, logic [15:0] d, bit lk, logic [3:0] sel,
                       int ra, bit req, logic [15:0] key, bit scan);
    bus.write     = wr;
    bus.addr      = 2'(a);
    bus.data_in   = d;
    bus.lock      = lk;
    bus.lock_sel  = sel;
    bus.rd_addr   = 2'(ra);
    bus.dbg_req   = req;
    bus.dbg_key   = key;
    bus.scan_mode = scan;
  endtask

  task automatic cyc(bit wr, int a, logic [15:0] d, bit lk, logic [3:0] sel,
                     int ra, bit req, logic [15:0] key, bit scan);
    @(negedge clk);
    drive(wr, a, d, lk, sel, ra, req, key, scan);
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(int ra, int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0, 4'h0, ra, 0, 16'h0, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear
  // without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    drive(0, 0, 16'h0, 0, 4'h0, 0, 0, 16'h0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_data_out",     bus.data_out,     0);
    chk("rst_lock_status",  bus.lock_status,  0);
    chk("rst_dbg_unlocked", bus.dbg_unlocked, 0);
    chk("rst_dbg_lockout",  bus.dbg_lockout,  0);
    chk("rst_wr_err",       bus.wr_err,       0);
    model_reset();
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    drive(0, 0, 16'h0, 0, 4'h0, 0, 0, 16'h0, 0);
    model_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_out",     bus.data_out,     0);
    chk("reset_lock_status",  bus.lock_status,  0);
    chk("reset_dbg_unlocked", bus.dbg_unlocked, 0);
    chk("reset_dbg_lockout",  bus.dbg_lockout,  0);
    chk("reset_wr_err",       bus.wr_err,       0);
    @(negedge clk);
    #1 rst = 1'b0;

    // 1: plain write and read back
    cyc(1, 1, 16'h1234, 0, 4'h0, 1, 0, 16'h0, 0);
    idle(1, 2);

    // 2: lock reg 1, blocked write, reg 0 still writable
    cyc(0, 0, 16'h0, 0, 4'b0010, 1, 0, 16'h0, 0);
    cyc(1, 1, 16'hFFFF, 0, 4'h0, 1, 0, 16'h0, 0);
    cyc(1, 0, 16'h5555, 0, 4'h0, 1, 0, 16'h0, 0);
    idle(0, 2);
    idle(1, 1);

    // 3: correct key, write during window, window length, blocked after
    unl_cnt = 0;
    cyc(0, 0, 16'h0, 0, 4'h0, 1, 1, KEY, 0);
    idle(1, 1);
    cyc(1, 1, 16'hBEEF, 0, 4'h0, 1, 0, 16'h0, 0);
    idle(1, 300);
    chk("unlock_window_cycles", unl_cnt, UNL);
    cyc(1, 1, 16'h0BAD, 0, 4'h0, 1, 0, 16'h0, 0);
    idle(1, 2);

    // 4: three bad keys -> lockout, good key afterwards ignored
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 16'h0, 0, 4'h0, 1, 1, 16'h0000, 0);
      idle(1, 2);
    end
    cyc(0, 0, 16'h0, 0, 4'h0, 1, 1, KEY, 0);
    idle(1, 4);
    chk("lockout_sticky", bus.dbg_lockout, 1);

    // 5: scan entry zeroizes, beats a simultaneous write, keeps lock bits
    async_reset();
    cyc(1, 0, 16'h1111, 0, 4'h0, 0, 0, 16'h0, 0);
    cyc(1, 2, 16'h2222, 0, 4'h0, 0, 0, 16'h0, 0);
    cyc(1, 3, 16'h3333, 0, 4'b0100, 0, 0, 16'h0, 0);
    cyc(1, 0, 16'h9999, 0, 4'h0, 2, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 0, 4'h0, 3, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 0, 4'h0, 0, 0, 16'h0, 0);
    idle(0, 1);
    idle(2, 1);
    idle(3, 2);

    // 6: reset mid-window, then unlock again
    cyc(0, 0, 16'h0, 0, 4'b1111, 0, 1, KEY, 0);
    idle(0, 5);
    async_reset();
    cyc(0, 0, 16'h0, 0, 4'h0, 0, 1, KEY, 0);
    idle(0, 4);
    chk("reunlock_after_reset", bus.dbg_unlocked, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) async_reset();
      else cyc($urandom_range(0, 1), $urandom_range(0, 3), 16'($urandom),
               ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0,
               $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 1) == 0) ? KEY : 16'($urandom),
               ($urandom_range(0, 39) == 0));
    end
    idle(0, 3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/locked_regbank_dbg.md
Name: locked_regbank_dbg

Overview:
- Parametrised bank of NREGS lockable data registers, each WIDTH bits, with a sticky lock bit per register.
- A debug unlock grants write access only after a key-checked challenge. The unlock is time-limited, and repeated key failures trigger a lockout.
- scan_mode zeroizes the bank instead of bypassing the lock.
- Sits between the configuration bus and protected control fields. Successor to the single-register lockable block.

Parameters:
WIDTH, 16, data width of each register
NREGS, 4, number of registers (>=2)
AW, $clog2(NREGS), address width (derived)
KEY, 16'hA5C3, debug unlock key (WIDTH bits)
UNLOCK_CYCLES, 256, cycles the debug unlock stays open (>=2)
MAX_FAIL, 3, failed key attempts before permanent lockout (>=1)

Ports:
Clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
write  in  1  write request
addr  in  AW  write address
Data_in  in  WIDTH  write data
Lock  in  1  set lock bits of all registers
lock_sel  in  NREGS  set lock bit of selected registers
rd_addr  in  AW  read address
dbg_req  in  1  debug unlock request, key presented on dbg_key
dbg_key  in  WIDTH  debug key
scan_mode  in  1  scan/test mode
Data_out  out  WIDTH  registered read data
lock_status  out  NREGS  current lock bits
dbg_unlocked  out  1  debug unlock window open
dbg_lockout  out  1  debug permanently locked out until reset
wr_err  out  1  one-cycle pulse: previous-cycle write was blocked

Behaviour:
- Reset (async, active-high) clears all registers, Data_out, lock_status, wr_err, fail counter and timer to 0. FSM goes to IDLE.
- Lock bits:
  - Set by Lock (all bits) or lock_sel[i] (bit i). Lock and lock_sel in the same cycle are OR-ed.
  - Lock bits are sticky and are cleared only by reset.
  - A new lock bit takes effect on the cycle after it is set.
- Write is accepted iff write & (~lock_status[addr] | dbg_unlocked) & ~scan_mode & ~scan_q.
  - scan_q is scan_mode registered.
  - An accepted write updates reg[addr] <= Data_in at the edge.
  - A blocked write leaves the register unchanged and sets wr_err=1 for exactly the next cycle.
  - write=0 gives wr_err=0.
- Read: Data_out <= reg[rd_addr] each cycle (1-cycle latency). While scan_mode=1, Data_out <= 0.
- Scan entry: on scan_mode & ~scan_q, all registers are zeroized and the FSM is forced to IDLE from UNLOCKED or CHECK. LOCKOUT is retained. Lock bits are unchanged. Zeroize wins over a simultaneous write.
- Debug FSM (state is registered):
  - IDLE: on dbg_req & ~scan_mode, capture dbg_key into key_q and go to CHECK.
  - CHECK (1 cycle), key_q==KEY: go to UNLOCKED, load timer = UNLOCKED_CYCLES-1, clear fail_cnt.
  - CHECK, mismatch: fail_cnt+1. If the result equals MAX_FAIL, go to LOCKOUT, else go to IDLE.
  - UNLOCKED: dbg_unlocked=1 and the timer decrements every cycle. Go to IDLE when timer==0 (window is exactly UNLOCK_CYCLES cycles) or when Lock=1 (relock on the next edge).
  - LOCKOUT: dbg_lockout=1. Terminal until reset.
  - dbg_req is ignored outside IDLE.
- dbg_unlocked = (state==UNLOCKED). It is valid for writes in the first UNLOCKED cycle.
- Simultaneous write and Lock to an unlocked register: the write succeeds and the lock applies from the next cycle.
- Reset mid-unlock or mid-lockout returns to IDLE with fail_cnt=0.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then write addr=1 Data_in=16'h1234 → after 1 cycle, reading rd_addr=1 gives Data_out=16'h1234 one cycle later; wr_err=0.
2. lock_sel=4'b0010, then write addr=1 16'hFFFF → register stays 16'h1234, wr_err pulses 1 cycle. A write to addr=0 still succeeds.
3. dbg_req with dbg_key=16'hA5C3 → dbg_unlocked rises 2 cycles after dbg_req. A write to locked addr=1 with 16'hBEEF succeeds. dbg_unlocked stays high exactly 256 cycles. A blocked write after the window sets wr_err.
4. Three dbg_req with key 16'h0000 → dbg_lockout=1 after the third CHECK. A subsequent correct key is ignored, and dbg_unlocked stays 0 until reset.
5. With registers loaded, raise scan_mode together with write addr=0 → all registers read 0 after scan_mode drops. Data_out=0 during scan. lock_status is unchanged.
6. Assert reset asynchronously mid-UNLOCKED → outputs clear immediately. dbg_unlocked=0 and lock_status=0. After release, a fresh correct key unlocks again.
